fp32_serial_sum_tree: RTL and testbench

- Collects a frame of N_INPUTS FP32 words arriving serially and sums them in a pipelined binary adder tree built from adder_floating_point32 instances (ADD_LAT cycles each).
- Emits one FP32 sum per frame.
- Used for neuron dot-product reduction in DQN layers of arbitrary width; supersedes fixed-width serial summers.
- Supports back-to-back frames with no bubbles, input gaps, and synchronous frame abort.

---
 rtl/fp32_sum_pkg.sv | 18 +
 rtl/adder_floating_point32.sv | 88 ++++++++
 rtl/fp32_adder_tree.sv | 45 ++++
 rtl/fp32_serial_sum_tree.sv | 112 +++++++++++
 tb/tb_fp32_serial_sum_tree.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_sum_pkg.sv
// Shared constants and helpers for the FP32 serial sum tree.
package fp32_sum_pkg;

  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE    = 32'h3F80_0000;
  localparam int          DEF_ADD_LAT = 7;

  // Ceiling log2, with 1 mapping to 0 (a single lane needs no tree levels).
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_floating_point32.sv
// FP32 adder, round-to-nearest-even, denormals flushed to zero; LAT-cycle registered output.
module adder_floating_point32
  import fp32_sum_pkg::*;
#(
  parameter int LAT = DEF_ADD_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        valid_o,
  output logic [31:0] sum_o
);

  logic [31:0] big, sml, res_d;
  logic [7:0]  eb, es, shamt;
  logic [26:0] mb_x, ms_x, ms_sh, norm;
  logic [27:0] acc;
  logic [4:0]  msb;
  logic [24:0] mant_rc;
  logic        rnd;
  int          e_n;

  always_comb begin
    big = a_i;
    sml = b_i;
    if (b_i[30:0] > a_i[30:0]) begin
      big = b_i;
      sml = a_i;
    end
    eb    = big[30:23];
    es    = sml[30:23];
    mb_x  = (eb == 8'd0) ? '0 : {1'b1, big[22:0], 3'b000};
    ms_x  = (es == 8'd0) ? '0 : {1'b1, sml[22:0], 3'b000};
    shamt = eb - es;
    // Alignment keeps shifted-out bits as a sticky bit for correct rounding.
    if (shamt > 8'd26) ms_sh = {26'b0, |ms_x};
    else ms_sh = (ms_x >> shamt) | {26'b0, |(ms_x & ~({27{1'b1}} << shamt))};
    if (big[31] == sml[31]) acc = {1'b0, mb_x} + {1'b0, ms_sh};
    else acc = {1'b0, mb_x} - {1'b0, ms_sh};
    msb = '0;
    for (int i = 0; i < 28; i++) begin
      if (acc[i]) msb = 5'(i);
    end
    e_n = int'(eb) + int'(msb) - 26;
    if (msb == 5'd27) norm = acc[27:1] | {26'b0, acc[0]};
    else norm = 27'(acc << (5'd26 - msb));
    rnd     = norm[2] & (norm[3] | (|norm[1:0]));
    mant_rc = {1'b0, norm[26:3]} + {24'b0, rnd};
    if (mant_rc[24]) e_n = e_n + 1;

    res_d = FP32_ZERO;
    if (eb == 8'hFF) begin
      if ((big[22:0] != 23'd0) || ((sml[30:0] == big[30:0]) && (sml[31] != big[31])))
        res_d = 32'h7FC0_0000;
      else
        res_d = big;
    end else if (acc == 28'd0) begin
      res_d = FP32_ZERO;
    end else if (e_n >= 255) begin
      res_d = {big[31], 8'hFF, 23'd0};
    end else if (e_n > 0) begin
      res_d = {big[31], 8'(e_n), mant_rc[24] ? mant_rc[23:1] : mant_rc[22:0]};
    end
  end

  logic [LAT-1:0] vld_q;
  logic [31:0]    dat_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= res_d;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[LAT-1];
  assign sum_o   = dat_q[LAT-1];

endmodule

// File: rtl/fp32_adder_tree.sv
// Pipelined binary FP32 adder tree over LANES (power of 2) lanes; one shared valid per level.
module fp32_adder_tree
  import fp32_sum_pkg::*;
#(
  parameter int LANES   = 32,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [LANES*32-1:0]   lanes_i,
  output logic                  valid_o,
  output logic [31:0]           sum_o
);

  localparam int D = clog2_min1(LANES);

  // Heap layout: node n sums children 2n+1 and 2n+2; leaves sit at LANES-1.. in lane order.
  logic [31:0]        node [2*LANES-1];
  logic [2*LANES-2:0] node_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES-1+i]     = lanes_i[i*32 +: 32];
    assign node_vld[LANES-1+i] = valid_i;
  end

  for (genvar d = 0; d < D; d++) begin : g_lvl
    for (genvar m = 0; m < (1 << d); m++) begin : g_add
      localparam int NI = (1 << d) - 1 + m;
      adder_floating_point32 #(.LAT(ADD_LAT)) u_add (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (node_vld[(1 << (d + 1)) - 1]),
        .a_i     (node[2*NI+1]),
        .b_i     (node[2*NI+2]),
        .valid_o (node_vld[NI]),
        .sum_o   (node[NI])
      );
    end
  end

  assign valid_o = node_vld[0];
  assign sum_o   = node[0];

endmodule

// File: rtl/fp32_serial_sum_tree.sv
// Collects N_INPUTS serial FP32 beats per frame and sums them through a pipelined adder tree.
// Optional SUM_BIAS_EN adds a per-frame bias (sampled with the last beat) after the tree.
module fp32_serial_sum_tree
  import fp32_sum_pkg::*;
#(
  parameter int N_INPUTS = 24,
  parameter int ADD_LAT  = DEF_ADD_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_clear,
  input  logic [31:0] i_bias,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_frame_done
);

  localparam int D  = clog2_min1(N_INPUTS);
  localparam int P  = 1 << D;
  localparam int CW = D + 1;
  localparam int NB = (N_INPUTS > 1) ? N_INPUTS - 1 : 1;

  logic [CW-1:0]   cnt_q;
  logic [31:0]     buf_q [NB];
  logic [P*32-1:0] launch_q, launch_d;
  logic            launch_vld_q;
  logic            last_beat;
  logic            tree_vld, sum_vld;
  logic [31:0]     tree_sum, sum_dat, data_q;

  // Clear outranks a coincident beat, so a cleared beat never closes a frame.
  assign last_beat    = i_valid && !i_clear && (cnt_q == CW'(N_INPUTS - 1));
  assign o_frame_done = last_beat;

  always_comb begin
    launch_d = '0;
    for (int k = 0; k < N_INPUTS - 1; k++) launch_d[k*32 +: 32] = buf_q[k];
    launch_d[(N_INPUTS-1)*32 +: 32] = i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      launch_q     <= '0;
      launch_vld_q <= 1'b0;
      for (int k = 0; k < NB; k++) buf_q[k] <= FP32_ZERO;
    end else begin
      launch_vld_q <= last_beat;
      if (last_beat) launch_q <= launch_d;
      if (i_clear) begin
        cnt_q <= '0;
      end else if (i_valid) begin
        if (last_beat) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) buf_q[k] <= i_data;
          end
        end
      end
    end
  end

  fp32_adder_tree #(.LANES(P), .ADD_LAT(ADD_LAT)) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (launch_vld_q),
    .lanes_i (launch_q),
    .valid_o (tree_vld),
    .sum_o   (tree_sum)
  );

`ifdef SUM_BIAS_EN
  localparam int BD = D * ADD_LAT;
  logic [31:0] bias_q [BD+1];

  // bias_q[0] lines up with launch_vld; the chain re-aligns it with the tree output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= BD; i++) bias_q[i] <= FP32_ZERO;
    end else begin
      if (last_beat) bias_q[0] <= i_bias;
      for (int i = 1; i <= BD; i++) bias_q[i] <= bias_q[i-1];
    end
  end

  adder_floating_point32 #(.LAT(ADD_LAT)) u_bias_add (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (tree_vld),
    .a_i     (tree_sum),
    .b_i     (bias_q[BD]),
    .valid_o (sum_vld),
    .sum_o   (sum_dat)
  );
`else
  assign sum_vld = tree_vld;
  assign sum_dat = tree_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= FP32_ZERO;
    else if (sum_vld) data_q <= sum_dat;
  end

  assign o_valid = sum_vld;
  assign o_data  = sum_vld ? sum_dat : data_q;

endmodule

// File: tb/tb_fp32_serial_sum_tree.sv
// Bench for fp32_serial_sum_tree: N=24 and N=5 instances against a real-arithmetic frame model.
module tb_fp32_serial_sum_tree;

  localparam int NA = 24;
  localparam int NB = 5;
`ifdef SUM_BIAS_EN
  localparam int LA = 1 + ($clog2(NA) + 1) * 7;
  localparam int LB = 1 + ($clog2(NB) + 1) * 7;
`else
  localparam int LA = 1 + $clog2(NA) * 7;
  localparam int LB = 1 + $clog2(NB) * 7;
`endif

  logic        clk, rst_n;
  logic        a_valid, a_clear, b_valid, b_clear;
  logic [31:0] a_data, a_bias, b_data, b_bias;
  logic        a_o_valid, a_frame_done, b_o_valid, b_frame_done;
  logic [31:0] a_o_data, b_o_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  real         acc_m [2];
  int          nb_m  [2];
  int          qa_cyc[$], qb_cyc[$];
  logic [31:0] qa_dat[$], qb_dat[$];
  logic [31:0] a_last, b_last;
  bit          ev_a, ev_b;

  fp32_serial_sum_tree #(.N_INPUTS(NA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_data(a_data), .i_clear(a_clear),
    .i_bias(a_bias), .o_valid(a_o_valid), .o_data(a_o_data), .o_frame_done(a_frame_done)
  );

  fp32_serial_sum_tree #(.N_INPUTS(NB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_data(b_data), .i_clear(b_clear),
    .i_bias(b_bias), .o_valid(b_o_valid), .o_data(b_o_data), .o_frame_done(b_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact FP32 encoding of a real that is representable (all bench values are).
  function automatic logic [31:0] to_fp(input real v);
    real  m;
    int   e;
    logic s;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic real rnd_val();
    return real'(int'($urandom_range(0, 160)) - 80) / 2.0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin acc_m[i] = 0.0; nb_m[i] = 0; end
    qa_cyc.delete(); qa_dat.delete(); qb_cyc.delete(); qb_dat.delete();
    a_last = 32'h0; b_last = 32'h0;
  endtask

  // One cycle on DUT sel; the other DUT idles.
  task automatic beat(input int sel, input bit v, input bit clr, input real x, input real bias);
    bit  fd;
    real s;
    @(negedge clk);
    fd = 1'b0;
    if (sel == 0) begin
      a_valid = v; a_clear = clr; a_data = to_fp(x); a_bias = to_fp(bias);
      b_valid = 1'b0; b_clear = 1'b0;
    end else begin
      b_valid = v; b_clear = clr; b_data = to_fp(x); b_bias = to_fp(bias);
      a_valid = 1'b0; a_clear = 1'b0;
    end
    if (clr) begin
      acc_m[sel] = 0.0; nb_m[sel] = 0;
    end else if (v) begin
      acc_m[sel] = acc_m[sel] + x;
      nb_m[sel]++;
      if (nb_m[sel] == ((sel == 0) ? NA : NB)) begin
        fd = 1'b1;
        s  = acc_m[sel];
`ifdef SUM_BIAS_EN
        s = s + bias;
`endif
        if (sel == 0) begin qa_cyc.push_back(cyc + LA); qa_dat.push_back(to_fp(s)); end
        else begin qb_cyc.push_back(cyc + LB); qb_dat.push_back(to_fp(s)); end
        acc_m[sel] = 0.0; nb_m[sel] = 0;
      end
    end
    #1;
    if (sel == 0) check_val("a_frame_done", 32'(a_frame_done), 32'(fd));
    else check_val("b_frame_done", 32'(b_frame_done), 32'(fd));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_valid = 1'b0; a_clear = 1'b0; b_valid = 1'b0; b_clear = 1'b0;
    end
  endtask

  task automatic frame(input int sel, input real x, input real bias);
    for (int k = 0; k < ((sel == 0) ? NA : NB); k++) beat(sel, 1'b1, 1'b0, x, bias);
  endtask

  task automatic random_run(input int sel, input int cycles);
    int r;
    for (int c = 0; c < cycles; c++) begin
      r = $urandom_range(0, 99);
      if (r < 3) beat(sel, $urandom_range(0, 1) == 1, 1'b1, rnd_val(), 0.0);
      else if (r < 25) beat(sel, 1'b0, 1'b0, rnd_val(), rnd_val());
      else beat(sel, 1'b1, 1'b0, rnd_val(), rnd_val());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      ev_a = (qa_cyc.size() > 0) && (qa_cyc[0] == cyc);
      check_val("a_o_valid", 32'(a_o_valid), 32'(ev_a));
      if (ev_a) begin
        void'(qa_cyc.pop_front());
        a_last = qa_dat.pop_front();
        check_val("a_o_data", a_o_data, a_last);
      end else if (!a_o_valid) begin
        check_val("a_hold", a_o_data, a_last);
      end
      ev_b = (qb_cyc.size() > 0) && (qb_cyc[0] == cyc);
      check_val("b_o_valid", 32'(b_o_valid), 32'(ev_b));
      if (ev_b) begin
        void'(qb_cyc.pop_front());
        b_last = qb_dat.pop_front();
        check_val("b_o_data", b_o_data, b_last);
      end else if (!b_o_valid) begin
        check_val("b_hold", b_o_data, b_last);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_clear = 1'b0; a_data = '0; a_bias = '0;
    b_valid = 1'b0; b_clear = 1'b0; b_data = '0; b_bias = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_a_o_valid", 32'(a_o_valid), 32'd0);
    check_val("rst_a_o_data", a_o_data, 32'h0);
    check_val("rst_a_frame_done", 32'(a_frame_done), 32'd0);
    check_val("rst_b_o_valid", 32'(b_o_valid), 32'd0);
    check_val("rst_b_o_data", b_o_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contiguous frame of 1.0, then N=5 frame 1..5 with random gaps.
    frame(0, 1.0, 0.0);
    idle(LA + 4);
    for (int k = 1; k <= NB; k++) begin
      repeat ($urandom_range(0, 3)) beat(1, 1'b0, 1'b0, 0.0, 0.0);
      beat(1, 1'b1, 1'b0, real'(k), 0.0);
    end
    idle(LB + 4);

    // Three frames back to back.
    frame(0, 1.0, 0.0);
    frame(0, 2.0, 0.0);
    frame(0, 0.5, 0.0);
    idle(LA + 4);

    // Abort after 10 beats; then clear coinciding with a beat.
    for (int k = 0; k < 10; k++) beat(0, 1'b1, 1'b0, 1.0, 0.0);
    beat(0, 1'b0, 1'b1, 0.0, 0.0);
    frame(0, 1.0, 0.0);
    for (int k = 0; k < 5; k++) beat(0, 1'b1, 1'b0, 3.0, 0.0);
    beat(0, 1'b1, 1'b1, 100.0, 0.0);
    frame(0, 1.0, 0.0);
    idle(LA + 4);

    // Reset with a frame in flight.
    frame(0, 1.0, 0.0);
    idle(20);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_mid_o_valid", 32'(a_o_valid), 32'd0);
    check_val("rst_mid_o_data", a_o_data, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_hold_o_data", a_o_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LA + 4);
    frame(0, 1.0, 0.0);
    idle(LA + 4);

    // Bias frame (bias only contributes when the bias feature is built in).
    frame(0, 1.0, 0.5);
    idle(LA + 4);

    random_run(0, 300);
    idle(LA + 4);
    random_run(1, 200);
    idle(LA + LB + 8);

    check_val("a_drain", 32'(qa_cyc.size()), 32'd0);
    check_val("b_drain", 32'(qb_cyc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
